// File: rtl/interface_axis_pkg.sv
// Shared definitions for the AXI4-Stream receiver and transmitter pair.
package interface_axis_pkg;

    localparam int AXIS_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } axis_state_t;

endpackage

// File: rtl/interface_axis_slave.sv
// AXI4-Stream receiver: writes a frame of 64-bit beats into [addr_start, addr_end)
// and reports completion and tlast/length mismatch.
module interface_axis_slave
    import interface_axis_pkg::*;
#(
    parameter int ADDR_BIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   recv_enable,
    output logic                   recv_done,
    output logic                   recv_error,
    output logic [ADDR_BIT-1:0]    beats_written,
    input  logic [ADDR_BIT-1:0]    addr_start,
    input  logic [ADDR_BIT-1:0]    addr_end,
    input  logic                   s_axis_tvalid,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic                   write_en,
    output logic [ADDR_BIT-1:0]    write_addr,
    output logic [AXIS_DATA_W-1:0] write_data
);

    axis_state_t            r_state;
    logic [ADDR_BIT-1:0]    r_addr_start;
    logic [ADDR_BIT-1:0]    r_len;
    logic [ADDR_BIT-1:0]    r_beats;
    logic                   r_error;
    logic                   r_done;
    logic                   r_wen;
    logic [ADDR_BIT-1:0]    r_waddr;
    logic [AXIS_DATA_W-1:0] r_wdata;

    logic [ADDR_BIT-1:0]    w_len;
    logic                   w_ready;
    logic                   w_beat;
    logic                   w_exp_last;

    // Handshake: a beat transfers on any cycle where tvalid and tready are both high;
    // tready is decoded from the state register alone and never looks at tvalid.
    assign w_ready    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_beat     = s_axis_tvalid && w_ready;
    assign w_len      = addr_end - addr_start;
    assign w_exp_last = (r_beats == (r_len - ADDR_BIT'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr_start <= '0;
            r_len        <= '0;
            r_beats      <= '0;
            r_error      <= 1'b0;
            r_done       <= 1'b0;
            r_wen        <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            r_wen  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (recv_enable) begin
                        r_addr_start <= addr_start;
                        r_len        <= w_len;
                        r_beats      <= '0;
                        r_error      <= 1'b0;
                        if (w_len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_beat) begin
                        r_wen   <= 1'b1;
                        r_waddr <= r_addr_start + r_beats;
                        r_wdata <= s_axis_tdata;
                        r_beats <= r_beats + ADDR_BIT'(1);
                        if (w_exp_last) begin
                            // Missing tlast on the expected last beat: flush the rest of the frame.
                            r_error <= !s_axis_tlast;
                            r_state <= s_axis_tlast ? ST_DONE : ST_DRAIN;
                            r_done  <= s_axis_tlast;
                        end else if (s_axis_tlast) begin
                            r_error <= 1'b1;
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_beat && s_axis_tlast) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = w_ready;
    assign recv_done     = r_done;
    assign recv_error    = r_error;
    assign beats_written = r_beats;
    assign write_en      = r_wen;
    assign write_addr    = r_waddr;
    assign write_data    = r_wdata;

endmodule
